// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU pipeline boundary registers: default widths,
// reset/bubble constants and the per-cycle stage action decode.
package cpu_pipe_pkg;

  localparam int CPU_IW = 32;
  localparam int CPU_AW = 32;

  localparam logic [31:0] CPU_NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] CPU_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    ACT_LOAD  = 2'd0,
    ACT_STALL = 2'd1,
    ACT_FLUSH = 2'd2
  } stage_act_e;

  // Flush wins over stall; a stage with neither loads from upstream.
  function automatic stage_act_e decode_action(input logic flush, input logic stall);
    stage_act_e act;
    if (flush)      act = ACT_FLUSH;
    else if (stall) act = ACT_STALL;
    else            act = ACT_LOAD;
    return act;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance monitoring.
// Clear has priority over increment; the count holds at all-ones.
module sat_counter #(
  parameter int CW = 8
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] COUNT_MAX = '1;

  // Count up on inc, stopping at the maximum instead of wrapping.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != COUNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register carrying instruction, PC, sideband and valid
// between two CPU stages, with stall/flush control, derived PC+4/PC+8 and
// saturating stall/bubble counters.
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int             IW       = CPU_IW,
  parameter int             AW       = CPU_AW,
  parameter int             SBW      = 8,
  parameter int             CW       = 8,
  parameter logic [IW-1:0]  NOP_WORD = IW'(CPU_NOP_WORD),
  parameter logic [AW-1:0]  RESET_PC = AW'(CPU_RESET_PC)
) (
  input  logic           CLK,
  input  logic           Reset,
  input  logic [IW-1:0]  instr_in,
  input  logic [AW-1:0]  pc_in,
  input  logic [SBW-1:0] sb_in,
  input  logic           valid_in,
  input  logic           stall,
  input  logic           flush,
  output logic [IW-1:0]  instr_out,
  output logic [AW-1:0]  pc_out,
  output logic [AW-1:0]  pc4_out,
  output logic [AW-1:0]  pc8_out,
  output logic [SBW-1:0] sb_out,
  output logic           valid_out,
  output logic [CW-1:0]  stall_cnt,
  output logic [CW-1:0]  bubble_cnt
);

  localparam logic [AW-1:0] PC_STEP4 = AW'(4);
  localparam logic [AW-1:0] PC_STEP8 = AW'(8);

  stage_act_e act;
  logic       stallClear;
  logic       stallInc;
  logic       bubbleInc;

  // Decode the single action taken at the next edge.
  always_comb begin
    act = decode_action(flush, stall);
  end

  assign stallClear = (act != ACT_STALL);
  assign stallInc   = (act == ACT_STALL);
  assign bubbleInc  = (act == ACT_FLUSH) || ((act == ACT_LOAD) && !valid_in);

  // Stage payload: bubble on flush or invalid load, hold on stall, else capture.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      instr_out <= NOP_WORD;
      pc_out    <= RESET_PC;
      sb_out    <= '0;
      valid_out <= 1'b0;
    end else begin
      case (act)
        ACT_FLUSH: begin
          instr_out <= NOP_WORD;
          pc_out    <= pc_in;
          sb_out    <= '0;
          valid_out <= 1'b0;
        end
        ACT_STALL: begin
          instr_out <= instr_out;
          pc_out    <= pc_out;
          sb_out    <= sb_out;
          valid_out <= valid_out;
        end
        default: begin
          pc_out <= pc_in;
          if (valid_in) begin
            instr_out <= instr_in;
            sb_out    <= sb_in;
            valid_out <= 1'b1;
          end else begin
            instr_out <= NOP_WORD;
            sb_out    <= '0;
            valid_out <= 1'b0;
          end
        end
      endcase
    end
  end

  assign pc4_out = pc_out + PC_STEP4;
  assign pc8_out = pc_out + PC_STEP8;

  sat_counter #(.CW(CW)) stallCounter (
    .CLK   (CLK),
    .Reset (Reset),
    .clear (stallClear),
    .inc   (stallInc),
    .count (stall_cnt)
  );

  sat_counter #(.CW(CW)) bubbleCounter (
    .CLK   (CLK),
    .Reset (Reset),
    .clear (1'b0),
    .inc   (bubbleInc),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed steps followed by random traffic,
// compared against a cycle-level behavioural model of the stage.
module tb_pipe_stage_reg;

  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic        CLK;
  logic        Reset;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic [7:0]  sb_in;
  logic        valid_in;
  logic        stall;
  logic        flush;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc4_out;
  logic [31:0] pc8_out;
  logic [7:0]  sb_out;
  logic        valid_out;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mInstr;
  logic [31:0] mPc;
  logic [7:0]  mSb;
  logic        mValid;
  int          mStall;
  int          mBubble;

  pipe_stage_reg #(.CW(CW)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .instr_in   (instr_in),
    .pc_in      (pc_in),
    .sb_in      (sb_in),
    .valid_in   (valid_in),
    .stall      (stall),
    .flush      (flush),
    .instr_out  (instr_out),
    .pc_out     (pc_out),
    .pc4_out    (pc4_out),
    .pc8_out    (pc8_out),
    .sb_out     (sb_out),
    .valid_out  (valid_out),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  // Free-running clock, period 10
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOne(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
      $error("[TB] check %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkOne({tag, ".instr"},  instr_out, mInstr);
    checkOne({tag, ".pc"},     pc_out, mPc);
    checkOne({tag, ".pc4"},    pc4_out, mPc + 32'd4);
    checkOne({tag, ".pc8"},    pc8_out, mPc + 32'd8);
    checkOne({tag, ".sb"},     {24'd0, sb_out}, {24'd0, mSb});
    checkOne({tag, ".valid"},  {31'd0, valid_out}, {31'd0, mValid});
    checkOne({tag, ".stall"},  {{(32-CW){1'b0}}, stall_cnt}, mStall);
    checkOne({tag, ".bubble"}, {{(32-CW){1'b0}}, bubble_cnt}, mBubble);
  endtask

  task automatic modelReset();
    mInstr  = 32'h0000_0000;
    mPc     = 32'h0000_3000;
    mSb     = 8'h00;
    mValid  = 1'b0;
    mStall  = 0;
    mBubble = 0;
  endtask

  // One clock edge of the stage, written from the action priority rules
  task automatic modelStep();
    if (flush) begin
      mInstr  = 32'h0000_0000;
      mSb     = 8'h00;
      mValid  = 1'b0;
      mPc     = pc_in;
      mBubble = (mBubble < MAXC) ? mBubble + 1 : MAXC;
      mStall  = 0;
    end else if (stall) begin
      mStall = (mStall < MAXC) ? mStall + 1 : MAXC;
    end else begin
      mPc = pc_in;
      if (valid_in) begin
        mInstr = instr_in;
        mSb    = sb_in;
        mValid = 1'b1;
      end else begin
        mInstr  = 32'h0000_0000;
        mSb     = 8'h00;
        mValid  = 1'b0;
        mBubble = (mBubble < MAXC) ? mBubble + 1 : MAXC;
      end
      mStall = 0;
    end
  endtask

  // Drive inputs away from the edge, clock once, then check after the edge
  task automatic applyStimulus(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                               input logic [7:0] sb, input logic valid, input logic stl, input logic fl);
    instr_in = instr;
    pc_in    = pc;
    sb_in    = sb;
    valid_in = valid;
    stall    = stl;
    flush    = fl;
    @(posedge CLK);
    modelStep();
    #1;
    checkOutput(tag);
    @(negedge CLK);
  endtask

  // Assert Reset between edges and check outputs before any edge arrives
  task automatic applyAsyncReset(input string tag);
    #2;
    Reset = 1'b1;
    #1;
    modelReset();
    checkOutput(tag);
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  initial begin
    Reset    = 1'b1;
    instr_in = '0;
    pc_in    = '0;
    sb_in    = '0;
    valid_in = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    modelReset();
    #2;
    checkOutput("reset");
    checkOne("resetPc4", pc4_out, 32'h0000_3004);
    checkOne("resetPc8", pc8_out, 32'h0000_3008);
    @(negedge CLK);
    Reset = 1'b0;

    applyStimulus("load1", 32'h3C01_1234, 32'h0000_3004, 8'hA5, 1'b1, 1'b0, 1'b0);
    checkOne("load1Pc8", pc8_out, 32'h0000_300C);

    applyStimulus("stall1", 32'h1111_1111, 32'h0000_4000, 8'h11, 1'b1, 1'b1, 1'b0);
    applyStimulus("stall2", 32'h2222_2222, 32'h0000_4004, 8'h22, 1'b0, 1'b1, 1'b0);
    applyStimulus("stall3", 32'h3333_3333, 32'h0000_4008, 8'h33, 1'b1, 1'b1, 1'b0);
    checkOne("stall3Cnt", {30'd0, stall_cnt}, 32'd3);
    applyStimulus("loadAfterStall", 32'h4444_4444, 32'h0000_400C, 8'h44, 1'b1, 1'b0, 1'b0);

    applyStimulus("stallFlush", 32'h5555_5555, 32'h0000_3010, 8'h55, 1'b1, 1'b1, 1'b1);
    checkOne("stallFlushBubble", {30'd0, bubble_cnt}, 32'd1);

    for (int i = 0; i < 6; i++)
      applyStimulus("stallSat", $urandom, $urandom, 8'($urandom), 1'b1, 1'b1, 1'b0);
    checkOne("stallSatCnt", {30'd0, stall_cnt}, 32'd3);

    for (int i = 0; i < 5; i++)
      applyStimulus("invalidLoad", $urandom, 32'h0000_5000 + 32'(i * 4), 8'($urandom), 1'b0, 1'b0, 1'b0);
    checkOne("bubbleSatCnt", {30'd0, bubble_cnt}, 32'd3);

    applyStimulus("pcWrap", 32'hDEAD_BEEF, 32'hFFFF_FFFC, 8'h7E, 1'b1, 1'b0, 1'b0);
    checkOne("pcWrap4", pc4_out, 32'h0000_0000);
    checkOne("pcWrap8", pc8_out, 32'h0000_0004);

    applyStimulus("preResetStall", 32'h6666_6666, 32'h0000_6000, 8'h66, 1'b1, 1'b1, 1'b0);
    applyAsyncReset("midStallReset");
    applyStimulus("postResetLoad", 32'h7777_7777, 32'h0000_7000, 8'h77, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      if ((i % 75) == 74) begin
        applyAsyncReset("randReset");
      end else begin
        applyStimulus("rand", $urandom, $urandom, 8'($urandom),
                      ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                      ($urandom_range(0, 5) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised fetch/decode-style pipeline boundary register for the CPU datapath, placed between any two stages (F/D first, then reused for D/E, E/M and M/W).
- Carries instruction word, PC and a sideband field, plus a valid bit.
- Supports stall (hold) and flush (bubble insert).
- Derives PC+4 and PC+8 internally from the registered PC.
- Keeps saturating stall and bubble counters for performance monitoring.

Parameters:
- IW, 32, instruction word width
- AW, 32, PC width
- SBW, 8, sideband width (control bits forwarded with the instruction; 0 not allowed, minimum 1)
- CW, 8, width of the stall and bubble counters
- NOP_WORD, 32'h0000_0000, instruction value loaded on reset, flush or invalid input
- RESET_PC, 32'h0000_3000, PC value after reset

Ports:
- CLK  in  1  clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-high reset
- instr_in  in  IW  instruction from upstream stage
- pc_in  in  AW  PC of instr_in
- sb_in  in  SBW  sideband from upstream
- valid_in  in  1  upstream slot holds a real instruction
- stall  in  1  hold all stage registers this cycle
- flush  in  1  replace stage contents with a bubble this cycle
- instr_out  out  IW  registered instruction
- pc_out  out  AW  registered PC
- pc4_out  out  AW  pc_out+4
- pc8_out  out  AW  pc_out+8
- sb_out  out  SBW  registered sideband
- valid_out  out  1  registered valid
- stall_cnt  out  CW  consecutive stall cycles, saturating
- bubble_cnt  out  CW  total bubbles inserted since reset, saturating

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-high, named Reset.
- Values while Reset=1, effective immediately without waiting for a clock edge:
  - instr_out=NOP_WORD
  - pc_out=RESET_PC
  - sb_out=0
  - valid_out=0
  - stall_cnt=0
  - bubble_cnt=0
- Reset mid-stall or mid-flush: all state is discarded; the first edge after Reset falls behaves as a normal cycle.
- Each rising edge with Reset=0 applies exactly one action, in priority order flush > stall > load:
  - FLUSH (flush=1, stall ignored):
    - instr_out<=NOP_WORD, sb_out<=0, valid_out<=0
    - pc_out<=pc_in, so the bubble carries the address for exception reporting
    - bubble_cnt increments, saturating
    - stall_cnt<=0
  - STALL (flush=0, stall=1):
    - instr_out, pc_out, sb_out and valid_out hold
    - stall_cnt increments, saturating at 2^CW-1
    - bubble_cnt holds
  - LOAD (flush=0, stall=0):
    - pc_out<=pc_in
    - if valid_in=1: instr_out<=instr_in, sb_out<=sb_in, valid_out<=1
    - if valid_in=0: instr_out<=NOP_WORD, sb_out<=0, valid_out<=0, and bubble_cnt increments, saturating
    - stall_cnt<=0
- Latency: one cycle from input to output on LOAD; zero-cycle combinational path from pc_out to pc4_out/pc8_out.
- Arithmetic: pc4_out=(pc_out+4) mod 2^AW and pc8_out=(pc_out+8) mod 2^AW; they wrap silently with no overflow flag.
- Counters never wrap: once at 2^CW-1 they hold until cleared (stall_cnt) or until reset (bubble_cnt).
- No path from any input to any output except through registers; pc4_out/pc8_out depend only on pc_out.

Decomposition:
- Shared package cpu_pipe_pkg holds:
  - default widths (IW, AW)
  - NOP_WORD and RESET_PC constants
  - a stage-action enum {ACT_LOAD, ACT_STALL, ACT_FLUSH}, decoded once per cycle from flush/stall
- One sub-module, sat_counter (parameter CW; ports: clear, inc, count), instantiated twice:
  - stall counter: clear on LOAD or FLUSH, inc on STALL
  - bubble counter: clear only by Reset, inc on FLUSH or invalid LOAD

Test Plan:
- Reset asserted between edges -> outputs change immediately: instr_out=0, pc_out=32'h3000, pc4_out=32'h3004, pc8_out=32'h3008, valid_out=0, both counters 0.
- LOAD instr_in=32'h3C01_1234, pc_in=32'h3004, valid_in=1 -> after one edge: instr_out=32'h3C01_1234, pc_out=32'h3004, pc4_out=32'h3008, pc8_out=32'h300C, valid_out=1.
- stall=1 for 3 edges while inputs change -> outputs frozen at prior values, stall_cnt=3; next LOAD edge -> new values captured, stall_cnt=0.
- stall=1 and flush=1 on the same edge with pc_in=32'h3010 -> instr_out=NOP_WORD, valid_out=0, pc_out=32'h3010, bubble_cnt+1, stall_cnt=0.
- CW=2, stall held for 6 edges -> stall_cnt reads 1,2,3,3,3,3. Then 5 invalid loads -> bubble_cnt saturates at 3.
- pc_in=32'hFFFF_FFFC loaded -> pc4_out=32'h0000_0000, pc8_out=32'h0000_0004.
